// File: rtl/clint_access_unit_if.sv
// Request and CLINT-bus signal bundle for clint_access_unit.
// The slave modport is the unit; the master modport is the requester plus the CLINT responder.
`ifndef XLEN
`define XLEN 32
`endif

interface clint_access_unit_if;
    logic               i_req_valid;
    logic               o_req_ready;
    logic               i_req_op;
    logic [63:0]        i_req_data;
    logic               o_rsp_valid;
    logic [63:0]        o_rsp_data;
    logic               o_wen;
    logic               o_ren;
    logic [`XLEN-1:0]   o_addr;
    logic [`XLEN-1:0]   o_wrdata;
    logic [`XLEN-1:0]   i_rddata;

    modport slave (
        input  i_req_valid, i_req_op, i_req_data, i_rddata,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_wen, o_ren, o_addr, o_wrdata
    );

    modport master (
        output i_req_valid, i_req_op, i_req_data, i_rddata,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_wen, o_ren, o_addr, o_wrdata
    );
endinterface

// File: rtl/clint_access_unit.sv
// 64-bit CLINT timer access over a 32-bit bus: tear-free mtime read (hi/lo/hi), mtimecmp0 write.
// Define CLINT_ACC_SAFE_CMP_EN to park mtimecmp0 low at all-ones before writing, avoiding transient interrupts.
`ifndef XLEN
`define XLEN 32
`endif

module clint_access_unit #(
    parameter logic [31:0] BASE_ADDR    = 32'h2000_0000,
    parameter logic [31:0] MTIMECMP_OFS = 32'h0000_4000,
    parameter logic [31:0] MTIME_LO_OFS = 32'h0000_BFF8,
    parameter logic [31:0] MTIME_HI_OFS = 32'h0000_BFFC
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    clint_access_unit_if.slave   io_bus
);

    localparam int unsigned XW = `XLEN;

    localparam logic [XW-1:0] A_MTIME_LO = XW'(BASE_ADDR) + XW'(MTIME_LO_OFS);
    localparam logic [XW-1:0] A_MTIME_HI = XW'(BASE_ADDR) + XW'(MTIME_HI_OFS);
    localparam logic [XW-1:0] A_CMP_LO   = XW'(BASE_ADDR) + XW'(MTIMECMP_OFS);
    localparam logic [XW-1:0] A_CMP_HI   = XW'(BASE_ADDR) + XW'(MTIMECMP_OFS) + XW'(32'd4);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_HI1    = 3'd1,
        RD_LO     = 3'd2,
        RD_HI2    = 3'd3,
        WR_LO_MAX = 3'd4,
        WR_HI     = 3'd5,
        WR_LO     = 3'd6,
        RSP       = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_hi1;
    logic [31:0] r_lo;
    logic [63:0] r_data;
    logic [63:0] r_rsp_data;
    logic [31:0] w_rd_word;
    logic        w_hi_match;
    logic        w_accept;

    assign w_rd_word  = io_bus.i_rddata[31:0];
    assign w_hi_match = (w_rd_word == r_hi1);
    assign w_accept   = (r_state == IDLE) && io_bus.i_req_valid;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (io_bus.i_req_valid) begin
`ifdef CLINT_ACC_SAFE_CMP_EN
                    w_next = io_bus.i_req_op ? WR_LO_MAX : RD_HI1;
`else
                    w_next = io_bus.i_req_op ? WR_LO : RD_HI1;
`endif
                end
            end
            RD_HI1:    w_next = RD_LO;
            RD_LO:     w_next = RD_HI2;
            RD_HI2:    w_next = w_hi_match ? RSP : RD_LO;
`ifdef CLINT_ACC_SAFE_CMP_EN
            WR_LO_MAX: w_next = WR_HI;
            WR_HI:     w_next = WR_LO;
            WR_LO:     w_next = RSP;
`else
            WR_LO_MAX: w_next = IDLE;
            WR_LO:     w_next = WR_HI;
            WR_HI:     w_next = RSP;
`endif
            RSP:       w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Bus and handshake outputs decoded from the state register
    always_comb begin
        io_bus.o_req_ready = 1'b0;
        io_bus.o_rsp_valid = 1'b0;
        io_bus.o_wen       = 1'b0;
        io_bus.o_ren       = 1'b0;
        io_bus.o_addr      = '0;
        io_bus.o_wrdata    = '0;
        case (r_state)
            IDLE: io_bus.o_req_ready = 1'b1;
            RD_HI1, RD_HI2: begin
                io_bus.o_ren  = 1'b1;
                io_bus.o_addr = A_MTIME_HI;
            end
            RD_LO: begin
                io_bus.o_ren  = 1'b1;
                io_bus.o_addr = A_MTIME_LO;
            end
            WR_LO_MAX: begin
                io_bus.o_wen    = 1'b1;
                io_bus.o_addr   = A_CMP_LO;
                io_bus.o_wrdata = XW'(32'hFFFF_FFFF);
            end
            WR_HI: begin
                io_bus.o_wen    = 1'b1;
                io_bus.o_addr   = A_CMP_HI;
                io_bus.o_wrdata = XW'(r_data[63:32]);
            end
            WR_LO: begin
                io_bus.o_wen    = 1'b1;
                io_bus.o_addr   = A_CMP_LO;
                io_bus.o_wrdata = XW'(r_data[31:0]);
            end
            RSP:     io_bus.o_rsp_valid = 1'b1;
            default: io_bus.o_req_ready = 1'b0;
        endcase
    end

    // Datapath: request latch, read capture, response hold
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hi1      <= '0;
            r_lo       <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) r_data <= io_bus.i_req_data;
            case (r_state)
                RD_HI1: r_hi1 <= w_rd_word;
                RD_LO:  r_lo  <= w_rd_word;
                RD_HI2: begin
                    if (w_hi_match) r_rsp_data <= {r_hi1, r_lo};
                    else            r_hi1      <= w_rd_word;
                end
                WR_HI, WR_LO: begin
                    if (w_next == RSP) r_rsp_data <= '0;
                end
                default: r_rsp_data <= r_rsp_data;
            endcase
        end
    end

    assign io_bus.o_rsp_data = r_rsp_data;

endmodule

// File: tb/tb_clint_access_unit.sv
// Self-checking bench for clint_access_unit with a behavioural CLINT responder (mtime, mtimecmp0, tip).
`ifndef XLEN
`define XLEN 32
`endif

module tb_clint_access_unit;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] A_LO = BASE + 32'h0000_BFF8;
    localparam logic [31:0] A_HI = BASE + 32'h0000_BFFC;
    localparam logic [31:0] A_CL = BASE + 32'h0000_4000;
    localparam logic [31:0] A_CH = BASE + 32'h0000_4004;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    clint_access_unit_if bus();

    clint_access_unit dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // CLINT responder model
    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic             t_inc    = 1'b0;
    logic             ld_t     = 1'b0;
    logic [63:0]      ld_t_val = 64'd0;
    logic             ld_c     = 1'b0;
    logic [63:0]      ld_c_val = 64'd0;
    logic [`XLEN-1:0] rd_model;
    logic             tip;

    always @(posedge clk) begin
        if (ld_t) mtime <= ld_t_val;
        else      mtime <= mtime + {63'd0, t_inc};
        if (ld_c) mtimecmp <= ld_c_val;
        else if (bus.o_wen) begin
            if (32'(bus.o_addr) == A_CL)      mtimecmp[31:0]  <= 32'(bus.o_wrdata);
            else if (32'(bus.o_addr) == A_CH) mtimecmp[63:32] <= 32'(bus.o_wrdata);
        end
    end

    assign tip = (mtime >= mtimecmp);

    always_comb begin
        rd_model = '0;
        if (bus.o_ren) begin
            if (32'(bus.o_addr) == A_LO)      rd_model = `XLEN'(mtime[31:0]);
            else if (32'(bus.o_addr) == A_HI) rd_model = `XLEN'(mtime[63:32]);
        end
    end

    assign bus.i_rddata = rd_model;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mtime value c cycles after a cycle in which it was m
    function automatic logic [63:0] mt(input logic [63:0] m, input logic i, input int c);
        return i ? m + 64'(c) : m;
    endfunction

    task automatic set_time(input logic [63:0] m, input logic i);
        ld_t = 1'b1; ld_t_val = m; t_inc = i;
        @(negedge clk);
        ld_t = 1'b0;
    endtask

    // Caller is at the negedge of the accept cycle with mtime == m; drives the request here.
    task automatic read_txn(input logic [63:0] m, input logic i, input bit hold, output int rsp_cyc,
                            output logic [63:0] exp);
        int k;
        k = 0;
        while (k < 8 && (mt(m, i, 1 + 2*k) >> 32) != (mt(m, i, 3 + 2*k) >> 32)) k++;
        rsp_cyc = 4 + 2*k;
        exp     = mt(m, i, 2 + 2*k);
        bus.i_req_valid = 1'b1;
        bus.i_req_op    = 1'b0;
        bus.i_req_data  = 64'(bus.i_req_data + 64'd1);
        chk("rd_accept_ready", 64'(bus.o_req_ready), 64'd1);
        for (int c = 1; c <= rsp_cyc; c++) begin
            @(negedge clk);
            if (!hold) bus.i_req_valid = 1'b0;
            chk("rd_busy_ready", 64'(bus.o_req_ready), 64'd0);
            chk("rd_wen", 64'(bus.o_wen), 64'd0);
            if (c < rsp_cyc) begin
                chk("rd_ren", 64'(bus.o_ren), 64'd1);
                chk("rd_addr", 64'(bus.o_addr), 64'((c % 2 == 1) ? A_HI : A_LO));
                chk("rd_rsp_early", 64'(bus.o_rsp_valid), 64'd0);
            end else begin
                chk("rd_rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
                chk("rd_rsp_data", bus.o_rsp_data, exp);
                chk("rd_rsp_ren", 64'(bus.o_ren), 64'd0);
                chk("rd_rsp_addr", 64'(bus.o_addr), 64'd0);
            end
        end
    endtask

    task automatic write_txn(input logic [63:0] d);
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        int n;
`ifdef CLINT_ACC_SAFE_CMP_EN
        n = 3;
        ea[0] = A_CL; ed[0] = 32'hFFFF_FFFF;
        ea[1] = A_CH; ed[1] = d[63:32];
        ea[2] = A_CL; ed[2] = d[31:0];
`else
        n = 2;
        ea[0] = A_CL; ed[0] = d[31:0];
        ea[1] = A_CH; ed[1] = d[63:32];
        ea[2] = 32'd0; ed[2] = 32'd0;
`endif
        ld_c = 1'b1; ld_c_val = 64'hFFFF_FFFF_FFFF_FFFF;
        set_time(64'd100, 1'b1);
        ld_c = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_req_op    = 1'b1;
        bus.i_req_data  = d;
        chk("wr_accept_ready", 64'(bus.o_req_ready), 64'd1);
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            bus.i_req_valid = 1'b0;
            chk("wr_tip", 64'(tip), 64'd0);
            chk("wr_ren", 64'(bus.o_ren), 64'd0);
            if (c <= n) begin
                chk("wr_wen", 64'(bus.o_wen), 64'd1);
                chk("wr_addr", 64'(bus.o_addr), 64'(ea[c-1]));
                chk("wr_data", 64'(bus.o_wrdata), 64'(ed[c-1]));
                chk("wr_rsp_early", 64'(bus.o_rsp_valid), 64'd0);
            end else begin
                chk("wr_rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
                chk("wr_rsp_data", bus.o_rsp_data, 64'd0);
                chk("wr_rsp_wen", 64'(bus.o_wen), 64'd0);
            end
        end
        @(negedge clk);
        chk("wr_cmp_final", mtimecmp, d);
        chk("wr_tip_after", 64'(tip), 64'd0);
    endtask

    initial begin
        int          rc;
        int          rc2;
        logic [63:0] ev;
        logic [63:0] ev2;
        logic [63:0] m;
        logic [31:0] lo;
        logic        ri;

        bus.i_req_valid = 1'b0;
        bus.i_req_op    = 1'b0;
        bus.i_req_data  = 64'd0;
        ld_t = 1'b1; ld_t_val = 64'd0;
        ld_c = 1'b1; ld_c_val = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        ld_t = 1'b0; ld_c = 1'b0;
        chk("rst_ready", 64'(bus.o_req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        chk("rst_rsp_data", bus.o_rsp_data, 64'd0);
        chk("rst_wen", 64'(bus.o_wen), 64'd0);
        chk("rst_ren", 64'(bus.o_ren), 64'd0);
        chk("rst_addr", 64'(bus.o_addr), 64'd0);
        chk("rst_wrdata", 64'(bus.o_wrdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stable mtime, no wrap
        set_time(64'h0000_0005_0000_0100, 1'b0);
        read_txn(64'h0000_0005_0000_0100, 1'b0, 1'b0, rc, ev);
        chk("rd_plain_latency", 64'(rc), 64'd4);

        // Low-word wrap between reads forces one retry
        set_time(64'h0000_0005_FFFF_FFFD, 1'b1);
        read_txn(64'h0000_0005_FFFF_FFFD, 1'b1, 1'b0, rc, ev);
        chk("rd_retry_latency", 64'(rc), 64'd6);
        chk("rd_retry_value", ev, 64'h0000_0006_0000_0001);
        @(negedge clk);
        chk("rsp_pulse_one_cycle", 64'(bus.o_rsp_valid), 64'd0);
        chk("rsp_data_hold", bus.o_rsp_data, 64'h0000_0006_0000_0001);

        write_txn(64'h0000_0001_0000_0200);

        for (int r = 0; r < 10; r++) begin
            lo = ($urandom_range(0, 1) == 1) ? $urandom() : 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
            m  = {29'd0, 3'($urandom_range(0, 7)), lo};
            ri = 1'($urandom_range(0, 1));
            set_time(m, ri);
            read_txn(m, ri, 1'b0, rc, ev);
        end

        for (int w = 0; w < 4; w++) begin
            m = {$urandom(), $urandom()};
            m[32] = 1'b1;
            write_txn(m);
        end

        // Requester holds valid across a whole read
        m = 64'h0000_0007_FFFF_FFFC;
        set_time(m, 1'b1);
        read_txn(m, 1'b1, 1'b1, rc, ev);
        @(negedge clk);
        read_txn(mt(m, 1'b1, rc + 1), 1'b1, 1'b0, rc2, ev2);
        chk("hold_second_value", bus.o_rsp_data, mt(m, 1'b1, rc + 1 + rc2 - 2));

        // Reset while in RD_LO
        set_time(64'h0000_0003_0000_0010, 1'b0);
        bus.i_req_valid = 1'b1;
        bus.i_req_op    = 1'b0;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_rdlo", 64'(bus.o_addr), 64'(A_LO));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_ready", 64'(bus.o_req_ready), 64'd1);
        chk("mid_rst_ren", 64'(bus.o_ren), 64'd0);
        chk("mid_rst_rsp_data", bus.o_rsp_data, 64'd0);
        for (int c = 0; c < 6; c++) begin
            chk("mid_rst_no_rsp", 64'(bus.o_rsp_valid), 64'd0);
            chk("mid_rst_idle_ren", 64'(bus.o_ren), 64'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
